// File: rtl/loa_key_arbiter.sv
// loa_key_arbiter
// Shares one key-locked lower-part-OR 16-bit adder between two requesters.
// A 32-bit key is shifted in serially (LSB first) before any operation is granted.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   key_load_i            one-cycle pulse requesting a (re)load of the key
//   key_sin_i             serial key bit, LSB first, sampled in each SHIFT cycle
//   req_valid_i[1:0]      per-requester request valid
//   req_a_i, req_b_i      operands; requester k uses bits [16k+15:16k]
//   req_ready_o[1:0]      combinational grant, one-hot or zero
//   add1_o, add2_o        registered operands to the adder
//   key_o                 registered active key to the adder key input
//   result_i              17-bit adder sum (combinational return)
//   key_valid_o           active key loaded and usable
//   resp_valid_o/id/data  held response, released by resp_ready_i
module loa_key_arbiter (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        key_load_i,
    input  logic        key_sin_i,
    input  logic [1:0]  req_valid_i,
    input  logic [31:0] req_a_i,
    input  logic [31:0] req_b_i,
    output logic [1:0]  req_ready_o,
    output logic [15:0] add1_o,
    output logic [15:0] add2_o,
    output logic [31:0] key_o,
    input  logic [16:0] result_i,
    output logic        key_valid_o,
    output logic        resp_valid_o,
    output logic        resp_id_o,
    output logic [16:0] resp_data_o,
    input  logic        resp_ready_i
);

    typedef enum logic [1:0] {StIdle, StShift, StArmed, StExec} state_e;

    state_e      state_q, state_d;
    logic        load_pend_q, load_pend_d;
    logic [31:0] shadow_q, shadow_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] key_q, key_d;
    logic        key_valid_q, key_valid_d;
    logic [15:0] add1_q, add1_d;
    logic [15:0] add2_q, add2_d;
    logic        op_id_q, op_id_d;
    logic        last_q, last_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_id_q, resp_id_d;
    logic [16:0] resp_data_q, resp_data_d;

    logic pend;
    logic resp_free;
    logic grant;
    logic win_id;

    // A pulse arriving this cycle counts as pending immediately, so a load from
    // IDLE enters SHIFT on the very next edge and blocks a grant in ARMED.
    assign pend      = load_pend_q | key_load_i;
    assign resp_free = ~resp_valid_q | resp_ready_i;
    assign grant     = (state_q == StArmed) && !pend && (|req_valid_i) && resp_free;
    // Round-robin only matters when both request; otherwise the lone requester wins.
    assign win_id    = (req_valid_i == 2'b11) ? ~last_q : req_valid_i[1];

    always_comb begin
        req_ready_o = 2'b00;
        if (grant) begin
            req_ready_o = win_id ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        state_d      = state_q;
        load_pend_d  = load_pend_q | key_load_i;
        shadow_d     = shadow_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        key_valid_d  = key_valid_q;
        add1_d       = add1_q;
        add2_d       = add2_q;
        op_id_d      = op_id_q;
        last_d       = last_q;
        resp_valid_d = resp_valid_q;
        resp_id_d    = resp_id_q;
        resp_data_d  = resp_data_q;

        if (resp_ready_i) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            StIdle, StArmed: begin
                if (pend) begin
                    load_pend_d = 1'b0;
                    cnt_d       = 5'd0;
                    key_valid_d = 1'b0;
                    state_d     = StShift;
                end else if (grant) begin
                    add1_d  = win_id ? req_a_i[31:16] : req_a_i[15:0];
                    add2_d  = win_id ? req_b_i[31:16] : req_b_i[15:0];
                    op_id_d = win_id;
                    last_d  = win_id;
                    state_d = StExec;
                end
            end
            StShift: begin
                shadow_d = {key_sin_i, shadow_q[31:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    key_d       = shadow_d;
                    key_valid_d = 1'b1;
                    state_d     = StArmed;
                end
            end
            StExec: begin
                resp_data_d  = result_i;
                resp_id_d    = op_id_q;
                resp_valid_d = 1'b1;
                state_d      = StArmed;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            load_pend_q  <= 1'b0;
            shadow_q     <= 32'd0;
            cnt_q        <= 5'd0;
            key_q        <= 32'd0;
            key_valid_q  <= 1'b0;
            add1_q       <= 16'd0;
            add2_q       <= 16'd0;
            op_id_q      <= 1'b0;
            last_q       <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_id_q    <= 1'b0;
            resp_data_q  <= 17'd0;
        end else begin
            state_q      <= state_d;
            load_pend_q  <= load_pend_d;
            shadow_q     <= shadow_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            key_valid_q  <= key_valid_d;
            add1_q       <= add1_d;
            add2_q       <= add2_d;
            op_id_q      <= op_id_d;
            last_q       <= last_d;
            resp_valid_q <= resp_valid_d;
            resp_id_q    <= resp_id_d;
            resp_data_q  <= resp_data_d;
        end
    end

    assign add1_o       = add1_q;
    assign add2_o       = add2_q;
    assign key_o        = key_q;
    assign key_valid_o  = key_valid_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_id_o    = resp_id_q;
    assign resp_data_o  = resp_data_q;

endmodule

// File: tb/tb_loa_key_arbiter.sv
// Directed bench for loa_key_arbiter: table of single operations plus
// hand-written key-load, contention, backpressure, reload and reset sequences.
module tb_loa_key_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        key_load;
    logic        key_sin;
    logic [1:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [1:0]  req_ready;
    logic [15:0] add1;
    logic [15:0] add2;
    logic [31:0] key;
    logic [16:0] result;
    logic        key_valid;
    logic        resp_valid;
    logic        resp_id;
    logic [16:0] resp_data;
    logic        resp_ready;

    int tests_run    = 0;
    int tests_failed = 0;

    // Adder model on the return path: exact unsigned 17-bit sum.
    assign result = {1'b0, add1} + {1'b0, add2};

    always #5 clk = ~clk;

    loa_key_arbiter dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .key_load_i   (key_load),
        .key_sin_i    (key_sin),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .add1_o       (add1),
        .add2_o       (add2),
        .key_o        (key),
        .result_i     (result),
        .key_valid_o  (key_valid),
        .resp_valid_o (resp_valid),
        .resp_id_o    (resp_id),
        .resp_data_o  (resp_data),
        .resp_ready_i (resp_ready)
    );

    typedef struct {
        logic [1:0]  valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  exp_ready;
        logic [15:0] exp_add1;
        logic [15:0] exp_add2;
        logic        exp_id;
        logic [16:0] exp_data;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_key"}, key, 32'd0);
        chk({tag, "_key_valid"}, {31'd0, key_valid}, 32'd0);
        chk({tag, "_add1"}, {16'd0, add1}, 32'd0);
        chk({tag, "_add2"}, {16'd0, add2}, 32'd0);
        chk({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'd0);
        chk({tag, "_resp_id"}, {31'd0, resp_id}, 32'd0);
        chk({tag, "_resp_data"}, {15'd0, resp_data}, 32'd0);
        chk({tag, "_req_ready"}, {30'd0, req_ready}, 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        key_load   = 1'b0;
        key_sin    = 1'b0;
        req_valid  = 2'b11;
        req_a      = 32'd0;
        req_b      = 32'd0;
        resp_ready = 1'b1;
        #1;
        check_zero("reset");
        tick();
        tick();
        rst       = 1'b0;
        req_valid = 2'b00;
    endtask

    // Starts in the first SHIFT cycle; ends in the first ARMED cycle.
    task automatic shift_bits(input logic [31:0] k, input logic [31:0] prev_key);
        for (int i = 0; i < 32; i++) begin
            key_load  = 1'b0;
            key_sin   = k[i];
            req_valid = 2'b11;
            #1;
            chk("shift_no_grant", {30'd0, req_ready}, 32'd0);
            chk("shift_key_valid", {31'd0, key_valid}, 32'd0);
            chk("shift_key_hold", key, prev_key);
            tick();
        end
        req_valid = 2'b00;
        #1;
        chk("load_key_valid", {31'd0, key_valid}, 32'd1);
        chk("load_key_value", key, k);
    endtask

    task automatic load_key(input logic [31:0] k, input logic [31:0] prev_key);
        key_load  = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("pulse_no_grant", {30'd0, req_ready}, 32'd0);
        tick();
        shift_bits(k, prev_key);
    endtask

    // Grant in the current (ARMED) cycle, check operands in EXEC and the response after.
    task automatic run_vec(input vec_t v, input int idx);
        req_valid = v.valid;
        req_a     = v.a;
        req_b     = v.b;
        #1;
        chk($sformatf("vec%0d_grant", idx), {30'd0, req_ready}, {30'd0, v.exp_ready});
        tick();
        req_valid = 2'b00;
        #1;
        chk($sformatf("vec%0d_add1", idx), {16'd0, add1}, {16'd0, v.exp_add1});
        chk($sformatf("vec%0d_add2", idx), {16'd0, add2}, {16'd0, v.exp_add2});
        chk($sformatf("vec%0d_exec_ready", idx), {30'd0, req_ready}, 32'd0);
        chk($sformatf("vec%0d_exec_rvalid", idx), {31'd0, resp_valid}, 32'd0);
        tick();
        #1;
        chk($sformatf("vec%0d_rvalid", idx), {31'd0, resp_valid}, 32'd1);
        chk($sformatf("vec%0d_rid", idx), {31'd0, resp_id}, {31'd0, v.exp_id});
        chk($sformatf("vec%0d_rdata", idx), {15'd0, resp_data}, {15'd0, v.exp_data});
        chk($sformatf("vec%0d_add1_hold", idx), {16'd0, add1}, {16'd0, v.exp_add1});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0] exp_g;

        // Round-robin trace starts with last-grant = 1 after reset.
        vecs[0] = '{2'b01, 32'h0000_0003, 32'h0000_0005, 2'b01, 16'h0003, 16'h0005, 1'b0, 17'h00008};
        vecs[1] = '{2'b11, 32'h1234_FFFF, 32'h4321_0001, 2'b10, 16'h1234, 16'h4321, 1'b1, 17'h05555};
        vecs[2] = '{2'b11, 32'hAAAA_FFFF, 32'h5555_FFFF, 2'b01, 16'hFFFF, 16'hFFFF, 1'b0, 17'h1FFFE};
        vecs[3] = '{2'b10, 32'hFFFF_0000, 32'h0001_0000, 2'b10, 16'hFFFF, 16'h0001, 1'b1, 17'h10000};
        vecs[4] = '{2'b10, 32'h00F0_1111, 32'h0F00_2222, 2'b10, 16'h00F0, 16'h0F00, 1'b1, 17'h00FF0};
        vecs[5] = '{2'b01, 32'hFFFF_0000, 32'hFFFF_0000, 2'b01, 16'h0000, 16'h0000, 1'b0, 17'h00000};
        vecs[6] = '{2'b11, 32'h0102_9999, 32'h0304_8888, 2'b10, 16'h0102, 16'h0304, 1'b1, 17'h00406};

        // Reset values, then no grant in IDLE before any key load.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b11;
            #1;
            chk("idle_no_grant", {30'd0, req_ready}, 32'd0);
            tick();
        end
        req_valid = 2'b00;

        // Key load: valid exactly 33 cycles after the pulse.
        load_key(32'hA5C3_0F96, 32'd0);

        // Table of single operations.
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: held response blocks grants until resp_ready rises.
        resp_ready = 1'b1;
        req_valid  = 2'b01;
        req_a      = 32'h0010_0100;
        req_b      = 32'h0020_0023;
        #1;
        chk("bp_first_grant", {30'd0, req_ready}, 32'd1);
        tick();
        req_valid  = 2'b00;
        resp_ready = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            req_valid = 2'b10;
            #1;
            chk("bp_no_grant", {30'd0, req_ready}, 32'd0);
            chk("bp_rvalid", {31'd0, resp_valid}, 32'd1);
            chk("bp_rdata_stable", {15'd0, resp_data}, 32'h0123);
            chk("bp_rid_stable", {31'd0, resp_id}, 32'd0);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp_grant_on_ready", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        #1;
        chk("bp_rvalid_cleared", {31'd0, resp_valid}, 32'd0);
        tick();
        #1;
        chk("bp_resp2_valid", {31'd0, resp_valid}, 32'd1);
        chk("bp_resp2_data", {15'd0, resp_data}, 32'h0030);
        chk("bp_resp2_id", {31'd0, resp_id}, 32'd1);

        // Reload pulsed during EXEC: response still delivered, then SHIFT.
        req_valid = 2'b01;
        req_a     = 32'h0000_0007;
        req_b     = 32'h0000_0009;
        #1;
        chk("rl_grant", {30'd0, req_ready}, 32'd1);
        tick();
        key_load  = 1'b1;
        req_valid = 2'b11;
        #1;
        chk("rl_exec_no_grant", {30'd0, req_ready}, 32'd0);
        tick();
        key_load = 1'b0;
        #1;
        chk("rl_resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("rl_resp_data", {15'd0, resp_data}, 32'h0010);
        chk("rl_resp_id", {31'd0, resp_id}, 32'd0);
        chk("rl_armed_no_grant", {30'd0, req_ready}, 32'd0);
        tick();
        shift_bits(32'h1357_9BDF, 32'hA5C3_0F96);
        req_valid = 2'b11;
        #1;
        chk("rl_grant_after_load", {30'd0, req_ready}, 32'd2);
        req_valid = 2'b00;
        tick();
        tick();

        // Reset in the middle of a key load (bit 17).
        key_load = 1'b1;
        tick();
        key_load = 1'b0;
        for (int i = 0; i < 17; i++) begin
            key_sin = 1'b1;
            tick();
        end
        rst = 1'b1;
        req_valid = 2'b11;
        #1;
        check_zero("midshift_reset");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            req_valid = 2'b11;
            #1;
            chk("post_reset_no_grant", {30'd0, req_ready}, 32'd0);
            chk("post_reset_key_valid", {31'd0, key_valid}, 32'd0);
            tick();
        end
        load_key(32'hDEAD_BEEF, 32'd0);

        // Contention after reset: 01,00,10,00,... with responses following.
        req_valid = 2'b11;
        req_a     = 32'h0011_0001;
        req_b     = 32'h0022_0002;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (c % 2 == 0) begin
                exp_g = ((c / 2) % 2 == 0) ? 2'b01 : 2'b10;
            end else begin
                exp_g = 2'b00;
            end
            chk($sformatf("cont_grant%0d", c), {30'd0, req_ready}, {30'd0, exp_g});
            if (c >= 2 && c % 2 == 0) begin
                chk($sformatf("cont_rvalid%0d", c), {31'd0, resp_valid}, 32'd1);
                chk($sformatf("cont_rid%0d", c), {31'd0, resp_id}, ((c / 2 - 1) % 2));
                chk($sformatf("cont_rdata%0d", c), {15'd0, resp_data},
                    ((c / 2 - 1) % 2 == 1) ? 32'h0033 : 32'h0003);
            end
            tick();
        end
        req_valid = 2'b00;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/loa_key_arbiter.md
LOA_KEY_ARBITER -- requirements
Module: loa_key_arbiter

Shares one key-locked lower-part-OR 16-bit adder between two requesters. Loads the 32-bit key serially before the adder is used.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 clk_i  input  1  clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  asynchronous reset, active-high.
REQ-004 key_load_i  input  1  one-cycle pulse that starts a key load.
REQ-005 key_sin_i  input  1  serial key bit, LSB first.
REQ-006 req_valid_i  input  2  request valid, one bit per requester k.
REQ-007 req_a_i, req_b_i  input  2x16 each  operands; requester k uses bits [16k+15:16k].
REQ-008 req_ready_o  output  2  grant/accept, one-hot or zero.
REQ-009 add1_o, add2_o  output  16 each  registered operands driven to the adder.
REQ-010 key_o  output  32  registered active key driven to the adder keyinput port.
REQ-011 result_i  input  17  adder sum (combinational return path).
REQ-012 key_valid_o  output  1  active key loaded and usable.
REQ-013 resp_valid_o  output  1  response holding.
REQ-014 resp_id_o  output  1  requester index of the response.
REQ-015 resp_data_o  output  17  captured sum.
REQ-016 resp_ready_i  input  1  response consumer ready.

Function
REQ-017 The FSM SHALL have four states: IDLE (no key), SHIFT, ARMED, EXEC.
REQ-018 A key_load_i pulse in any state SHALL set load_pend.
REQ-019 In IDLE or ARMED with load_pend=1, the block SHALL clear load_pend, clear the shift counter, deassert key_valid_o, and go to SHIFT next cycle.
REQ-020 In ARMED, load_pend SHALL take priority over any grant.
REQ-021 In each SHIFT cycle the block SHALL perform shadow <= {key_sin_i, shadow[31:1]} and increment a 5-bit counter.
REQ-022 On the 32nd SHIFT cycle (counter=31), key_o SHALL take the final shadow value, key_valid_o SHALL go to 1 and the state SHALL go to ARMED.
REQ-023 During SHIFT, key_o SHALL hold its previous value.
REQ-024 A key_load_i pulse during SHIFT SHALL restart the load after the current one completes (via load_pend).
REQ-025 Grant condition: state ARMED, load_pend=0, any req_valid_i set, and (resp_valid_o=0 or resp_ready_i=1).
REQ-026 req_ready_o SHALL be combinational and asserted only in the grant cycle.
REQ-027 Arbitration SHALL be round-robin on a last-grant bit: with both requests valid, the requester not granted last SHALL win.
REQ-028 With one request valid, that requester SHALL win regardless of last-grant.
REQ-029 On grant, at the clock edge, the block SHALL load add1_o/add2_o with the winner's operands, record resp_id, update last-grant, and go to EXEC.
REQ-030 In EXEC (one cycle) the block SHALL set resp_data_o<=result_i, resp_id_o<=recorded id, resp_valid_o<=1, then return to ARMED.
REQ-031 Latency SHALL be 2 cycles from grant to resp_valid_o; peak throughput SHALL be one operation per 2 cycles.
REQ-032 resp_valid_o SHALL clear on resp_ready_i unless a new EXEC capture occurs in the same cycle.
REQ-033 resp_data_o and resp_id_o SHALL be stable while resp_valid_o=1 and resp_ready_i=0.
REQ-034 add1_o/add2_o SHALL hold their values between operations.
REQ-035 In IDLE and SHIFT, req_ready_o SHALL be 00.
REQ-036 All values SHALL be unsigned; result width SHALL be 17 bits, passed through unmodified.

Reset
REQ-037 rst_i SHALL immediately force: state IDLE; key_o, shadow, counter, add1_o, add2_o, resp_data_o = 0; key_valid_o, resp_valid_o, resp_id_o, load_pend = 0; last-grant = 1 (requester 0 first).
REQ-038 Reset mid-SHIFT or mid-EXEC SHALL discard the partial key or operation; no response SHALL be produced.
REQ-039 After reset release, a key load SHALL be required before any grant.

Verification
REQ-040 Key load: reset, pulse key_load_i, shift 32'hA5C3_0F96 LSB first -> key_o=32'hA5C3_0F96 and key_valid_o=1 exactly 33 cycles after the pulse; no grant before that.
REQ-041 Single op: req0 a=16'h0003, b=16'h0005, model returns 17'h00008 -> req_ready_o=01 in cycle T; add1_o=3, add2_o=5 from T+1; resp_valid_o=1, resp_id_o=0, resp_data_o=8 at T+2.
REQ-042 Contention: both requesters valid continuously, resp_ready_i=1 -> grants alternate 01,10,01,10 every 2 cycles, starting with 01 after reset.
REQ-043 Backpressure: resp_ready_i=0 with a response held -> req_ready_o=00; resp_data_o stable; the grant occurs in the cycle resp_ready_i rises.
REQ-044 Reload during EXEC: key_load_i pulsed in EXEC -> response still delivered, no further grant, SHIFT entered from the next ARMED cycle, key_valid_o=0 throughout the load.
REQ-045 Reset mid-SHIFT at bit 17 -> all outputs zero; IDLE; no grant until a full 32-bit reload completes.
